// File: rtl/rob_retire.sv
// ---------------------------------------------------------------------------
// rob_retire
//   Reorder-buffer storage and in-order commit engine. Decode allocates up
//   to four entries per cycle at the tail. Four forwarding buses mark entries
//   complete. Up to two completed entries retire per cycle from the head and
//   drive the two register-file write ports.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               discard every entry (mispredict recovery)
//   alloc_n             entries to allocate this cycle (0..4)
//   alloc_pc/wr/dst/halt  per-slot allocation fields, slot 0 in the low bits
//   alloc_ok            at least four entries free (combinational)
//   tail_idx            index given to allocation slot 0
//   forwardA..D         {valid, rob index, value} completion buses
//   wen/waddr/wdata 0,1 register-file write ports (registered)
//   retire_pc0/1        PCs of the retiring entries
//   retire_cnt          entries retired on the last edge
//   count               occupied entries
//   halted              sticky, set once a HALT entry retires
// ---------------------------------------------------------------------------
module rob_retire #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [2:0]       alloc_n,
    input  logic [63:0]      alloc_pc,
    input  logic [3:0]       alloc_wr,
    input  logic [11:0]      alloc_dst,
    input  logic [3:0]       alloc_halt,
    output logic             alloc_ok,
    output logic [IDX_W-1:0] tail_idx,
    input  logic [22:0]      forwardA,
    input  logic [22:0]      forwardB,
    input  logic [22:0]      forwardC,
    input  logic [22:0]      forwardD,
    output logic             wen0,
    output logic             wen1,
    output logic [2:0]       waddr0,
    output logic [2:0]       waddr1,
    output logic [15:0]      wdata0,
    output logic [15:0]      wdata1,
    output logic [15:0]      retire_pc0,
    output logic [15:0]      retire_pc1,
    output logic [1:0]       retire_cnt,
    output logic [IDX_W:0]   count,
    output logic             halted
);

    localparam int CNT_W = IDX_W + 1;

    // Entry storage. busy/ready are control state and reset; the payload
    // fields are only meaningful while busy and are never reset.
    logic        busy  [DEPTH];
    logic        ready [DEPTH];
    logic [15:0] value [DEPTH];
    logic [15:0] pc    [DEPTH];
    logic        wr    [DEPTH];
    logic [2:0]  dst   [DEPTH];
    logic        halt  [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;

    // Bus 3 (D) is applied last inside the loops, so it wins same-index races.
    logic [3:0][22:0] fwd_bus;
    assign fwd_bus = {forwardD, forwardC, forwardB, forwardA};

    // Allocation acceptance: all-or-nothing against the current occupancy,
    // so space freed by a same-cycle retire is not visible until next cycle.
    logic [CNT_W-1:0] free;
    logic             alloc_go;
    logic [2:0]       alloc_amt;

    assign free      = CNT_W'(DEPTH) - count;
    assign alloc_ok  = (free >= CNT_W'(4));
    assign alloc_go  = (alloc_n != 3'd0) && (alloc_n <= 3'd4) &&
                       (CNT_W'(alloc_n) <= free);
    assign alloc_amt = alloc_go ? alloc_n : 3'd0;
    assign tail_idx  = tail;

    // Retire selection from registered ready bits only (no bypass from the
    // forwarding buses). A HALT in slot 0 keeps slot 1 from retiring.
    logic [IDX_W-1:0] h0;
    logic [IDX_W-1:0] h1;
    logic             ret0;
    logic             ret1;
    logic             same_dst;
    logic [1:0]       ret_cnt;

    assign h0       = head;
    assign h1       = head + IDX_W'(1);
    assign ret0     = !halted && busy[h0] && ready[h0];
    assign ret1     = ret0 && busy[h1] && ready[h1] && !halt[h0];
    // Two writes to one register in the same cycle: the younger one wins.
    assign same_dst = ret1 && wr[h0] && wr[h1] && (dst[h0] == dst[h1]);
    assign ret_cnt  = {1'b0, ret0} + {1'b0, ret1};

    // Control state and registered retire outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            wen0       <= 1'b0;
            wen1       <= 1'b0;
            waddr0     <= '0;
            waddr1     <= '0;
            wdata0     <= '0;
            wdata1     <= '0;
            retire_pc0 <= '0;
            retire_pc1 <= '0;
            retire_cnt <= '0;
            halted     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                busy[i]  <= 1'b0;
                ready[i] <= 1'b0;
            end
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            wen0       <= 1'b0;
            wen1       <= 1'b0;
            retire_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy[i]  <= 1'b0;
                ready[i] <= 1'b0;
            end
        end else begin
            // Writeback: only entries that are currently busy accept a result.
            for (int k = 0; k < 4; k++) begin
                if (fwd_bus[k][22] && busy[fwd_bus[k][16 +: IDX_W]])
                    ready[fwd_bus[k][16 +: IDX_W]] <= 1'b1;
            end

            // Retire clears after writeback so a stray forward cannot
            // resurrect a retiring entry.
            if (ret0) begin
                busy[h0]  <= 1'b0;
                ready[h0] <= 1'b0;
            end
            if (ret1) begin
                busy[h1]  <= 1'b0;
                ready[h1] <= 1'b0;
            end

            // Allocation only ever targets free entries.
            if (alloc_go) begin
                for (int k = 0; k < 4; k++) begin
                    if (3'(k) < alloc_n) begin
                        busy[tail + IDX_W'(k)]  <= 1'b1;
                        ready[tail + IDX_W'(k)] <= 1'b0;
                    end
                end
            end

            head  <= head + IDX_W'(ret_cnt);
            tail  <= tail + IDX_W'(alloc_amt);
            count <= count + CNT_W'(alloc_amt) - CNT_W'(ret_cnt);

            // Commit stage boundary: register-file ports.
            wen0       <= ret0 && wr[h0] && !same_dst;
            wen1       <= ret1 && wr[h1];
            retire_cnt <= ret_cnt;
            if (ret0) begin
                waddr0     <= dst[h0];
                wdata0     <= value[h0];
                retire_pc0 <= pc[h0];
            end
            if (ret1) begin
                waddr1     <= dst[h1];
                wdata1     <= value[h1];
                retire_pc1 <= pc[h1];
            end
            if ((ret0 && halt[h0]) || (ret1 && halt[h1]))
                halted <= 1'b1;
        end
    end

    // Entry payload: results from the buses, fields from allocation.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (fwd_bus[k][22] && busy[fwd_bus[k][16 +: IDX_W]])
                value[fwd_bus[k][16 +: IDX_W]] <= fwd_bus[k][15:0];
        end
        if (alloc_go) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < alloc_n) begin
                    pc[tail + IDX_W'(k)]   <= alloc_pc[16*k +: 16];
                    wr[tail + IDX_W'(k)]   <= alloc_wr[k];
                    dst[tail + IDX_W'(k)]  <= alloc_dst[3*k +: 3];
                    halt[tail + IDX_W'(k)] <= alloc_halt[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// ---------------------------------------------------------------------------
// tb_rob_retire
//   Directed bench for rob_retire: reset state, pair retire, in-order
//   commit, full/wrap behaviour, same-destination pairs, flush, HALT, and
//   asynchronous reset mid-operation. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_rob_retire;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [2:0]  alloc_n;
    logic [63:0] alloc_pc;
    logic [3:0]  alloc_wr;
    logic [11:0] alloc_dst;
    logic [3:0]  alloc_halt;
    logic        alloc_ok;
    logic [5:0]  tail_idx;
    logic [22:0] forwardA, forwardB, forwardC, forwardD;
    logic        wen0, wen1;
    logic [2:0]  waddr0, waddr1;
    logic [15:0] wdata0, wdata1, retire_pc0, retire_pc1;
    logic [1:0]  retire_cnt;
    logic [6:0]  count;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    rob_retire #(.DEPTH(64), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_n(alloc_n), .alloc_pc(alloc_pc), .alloc_wr(alloc_wr),
        .alloc_dst(alloc_dst), .alloc_halt(alloc_halt),
        .alloc_ok(alloc_ok), .tail_idx(tail_idx),
        .forwardA(forwardA), .forwardB(forwardB),
        .forwardC(forwardC), .forwardD(forwardD),
        .wen0(wen0), .wen1(wen1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .retire_pc0(retire_pc0), .retire_pc1(retire_pc1),
        .retire_cnt(retire_cnt), .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] mk(input int idx, input logic [15:0] v);
        return {1'b1, 6'(idx), v};
    endfunction

    task automatic fwd_clear();
        forwardA = '0; forwardB = '0; forwardC = '0; forwardD = '0;
    endtask

    task automatic alloc(input logic [2:0] n, input logic [63:0] pcs,
                         input logic [11:0] dsts, input logic [3:0] wrs,
                         input logic [3:0] hts);
        alloc_n = n; alloc_pc = pcs; alloc_dst = dsts;
        alloc_wr = wrs; alloc_halt = hts;
        tick();
        alloc_n = 3'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_n = '0; alloc_pc = '0;
        alloc_wr = '0; alloc_dst = '0; alloc_halt = '0;
        fwd_clear();
        tick(); tick();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_tail", tail_idx, 0);
        chk("rst_wen0", wen0, 0);
        chk("rst_rcnt", retire_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_alloc_ok", alloc_ok, 1);
        rst = 1'b0;
        tick();

        // 1: allocate four, complete 0 and 1, pair retire
        alloc(3'd4, {16'd6, 16'd4, 16'd2, 16'd0}, {3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 4'h0);
        chk("t1_tail", tail_idx, 4);
        chk("t1_count", count, 4);
        chk("t1_wen0", wen0, 0);
        forwardA = mk(0, 16'h0011);
        forwardB = mk(1, 16'h0022);
        tick();
        fwd_clear();
        chk("t1_no_bypass", retire_cnt, 0);
        tick();
        chk("t1_wen0", wen0, 1);
        chk("t1_waddr0", waddr0, 1);
        chk("t1_wdata0", wdata0, 16'h0011);
        chk("t1_wen1", wen1, 1);
        chk("t1_waddr1", waddr1, 2);
        chk("t1_wdata1", wdata1, 16'h0022);
        chk("t1_pc1", retire_pc1, 2);
        chk("t1_rcnt", retire_cnt, 2);
        chk("t1_count2", count, 2);
        tick();
        chk("t1_idle_wen0", wen0, 0);
        chk("t1_hold_wdata0", wdata0, 16'h0011);

        // 2: in-order commit (head=2, entries 2,3)
        forwardC = mk(3, 16'h0033);
        tick();
        fwd_clear();
        tick();
        chk("t2_blocked_rcnt", retire_cnt, 0);
        chk("t2_blocked_count", count, 2);
        forwardD = mk(2, 16'h0044);
        tick();
        fwd_clear();
        tick();
        chk("t2_rcnt", retire_cnt, 2);
        chk("t2_waddr0", waddr0, 3);
        chk("t2_wdata0", wdata0, 16'h0044);
        chk("t2_waddr1", waddr1, 4);
        chk("t2_wdata1", wdata1, 16'h0033);
        chk("t2_count", count, 0);

        // 3: walk head/tail to 63, fill, reject, retire two, wrap tail
        for (int i = 0; i < 14; i++)
            alloc(3'd4, '0, '0, 4'h0, 4'h0);
        alloc(3'd3, '0, '0, 4'h0, 4'h0);
        chk("t3_tail63", tail_idx, 63);
        for (int i = 4; i < 63; i += 4) begin
            forwardA = mk(i, 16'h1);
            forwardB = (i + 1 < 63) ? mk(i + 1, 16'h1) : 23'd0;
            forwardC = (i + 2 < 63) ? mk(i + 2, 16'h1) : 23'd0;
            forwardD = (i + 3 < 63) ? mk(i + 3, 16'h1) : 23'd0;
            tick();
        end
        fwd_clear();
        for (int c = 0; c < 100 && count != 0; c++)
            tick();
        chk("t3_drain", count, 0);
        for (int i = 0; i < 16; i++)
            alloc(3'd4, '0, '0, 4'h0, 4'h0);
        chk("t3_full_count", count, 64);
        chk("t3_full_alloc_ok", alloc_ok, 0);
        chk("t3_full_tail", tail_idx, 63);
        alloc(3'd2, '0, '0, 4'h0, 4'h0);
        chk("t3_reject_count", count, 64);
        chk("t3_reject_tail", tail_idx, 63);
        forwardA = mk(63, 16'h5);
        forwardB = mk(0, 16'h6);
        tick();
        fwd_clear();
        tick();
        chk("t3_ret_rcnt", retire_cnt, 2);
        chk("t3_ret_count", count, 62);
        alloc(3'd2, '0, '0, 4'h0, 4'h0);
        chk("t3_wrap_tail", tail_idx, 1);
        chk("t3_wrap_count", count, 64);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_count", count, 0);
        chk("t3_flush_tail", tail_idx, 0);

        // 4: same-destination pair, younger wins
        alloc(3'd2, {32'd0, 16'h0102, 16'h0100}, {6'd0, 3'd5, 3'd5}, 4'h3, 4'h0);
        forwardA = mk(0, 16'h1234);
        forwardB = mk(1, 16'hBEEF);
        tick();
        fwd_clear();
        tick();
        chk("t4_wen0", wen0, 0);
        chk("t4_wen1", wen1, 1);
        chk("t4_waddr1", waddr1, 5);
        chk("t4_wdata1", wdata1, 16'hBEEF);
        chk("t4_rcnt", retire_cnt, 2);

        // 6: flush with ten busy entries and a forward in flight
        alloc(3'd4, '0, {3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 4'h0);
        alloc(3'd4, '0, {3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 4'h0);
        alloc(3'd2, '0, {6'd0, 3'd2, 3'd1}, 4'h3, 4'h0);
        chk("t6_pre_count", count, 10);
        forwardA = mk(2, 16'hAAAA);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        fwd_clear();
        chk("t6_count", count, 0);
        chk("t6_tail", tail_idx, 0);
        chk("t6_wen0", wen0, 0);
        chk("t6_rcnt", retire_cnt, 0);
        forwardA = mk(3, 16'h7777);
        tick();
        fwd_clear();
        alloc(3'd4, {16'h0206, 16'h0204, 16'h0202, 16'h0200},
              {3'd4, 3'd3, 3'd2, 3'd1}, 4'hF, 4'h0);
        forwardA = mk(0, 16'h0001);
        forwardB = mk(1, 16'h0002);
        forwardC = mk(2, 16'h0003);
        tick();
        fwd_clear();
        tick();
        chk("t6_ret_a", retire_cnt, 2);
        tick();
        chk("t6_ret_b", retire_cnt, 1);
        chk("t6_ret_b_data", wdata0, 16'h0003);
        tick();
        chk("t6_late_fwd_ignored", retire_cnt, 0);
        chk("t6_late_count", count, 1);

        flush = 1'b1;
        tick();
        flush = 1'b0;

        // 5: [ADD, HALT, ADD]
        alloc(3'd3, {16'd0, 16'h0304, 16'h0302, 16'h0300},
              {3'd0, 3'd2, 3'd0, 3'd1}, 4'b0101, 4'b0010);
        forwardA = mk(0, 16'h00A1);
        forwardB = mk(1, 16'h00B2);
        forwardC = mk(2, 16'h00C3);
        tick();
        fwd_clear();
        tick();
        chk("t5_rcnt", retire_cnt, 2);
        chk("t5_wen0", wen0, 1);
        chk("t5_waddr0", waddr0, 1);
        chk("t5_wen1", wen1, 0);
        chk("t5_pc1", retire_pc1, 16'h0302);
        chk("t5_halted", halted, 1);
        chk("t5_count", count, 1);
        tick(); tick(); tick();
        chk("t5_stuck_rcnt", retire_cnt, 0);
        chk("t5_stuck_count", count, 1);
        alloc(3'd1, '0, '0, 4'h0, 4'h0);
        chk("t5_alloc_halted", count, 2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_halted", halted, 1);
        chk("t5_flush_count", count, 0);

        // Asynchronous reset mid-operation
        alloc(3'd2, '0, '0, 4'h0, 4'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_halted", halted, 0);
        chk("ar_tail", tail_idx, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_wen0", wen0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
